axi_addr_guard: RTL and testbench
=================================

// Module: axi_addr_guard
// PURPOSE
//  AXI4 address-window firewall directly upstream of the 256 MiB address remapper, which discards addr[31:28].
//  In-window bursts are forwarded unchanged; out-of-window bursts never reach the master side.
//  Out-of-window writes have their W data drained and get DECERR; out-of-window reads get DECERR beats.
//  Prevents aliasing of stray core accesses onto DDR.
// PARAMETERS
//  ADDR_W    32     address width
//  DATA_W    64     data width
//  ID_W      4      AXI ID width
//  WIN_BITS  28     log2 of window size; in-window iff addr[ADDR_W-1:WIN_BITS] == WIN_TAG
//  WIN_TAG   4'h0   required upper address bits, width ADDR_W-WIN_BITS
//  MAX_OUTS  15     max outstanding forwarded bursts per direction
// PORTS
//  aclk          in   1        single clock; all logic rising-edge
//  aresetn       in   1        asynchronous assert, active-low reset
//  s_axi_aw*     in/out  AXI4  slave AW: id, addr, len, size, burst, lock, cache, prot, qos, valid, ready
//  s_axi_w*      in/out  AXI4  slave W: data, strb, last, valid, ready
//  s_axi_b*      out/in  AXI4  slave B: id, resp, valid, ready
//  s_axi_ar*     in/out  AXI4  slave AR: same fields as AW
//  s_axi_r*      out/in  AXI4  slave R: id, data, resp, last, valid, ready
//  m_axi_*       mirror        master side, same five channels, feeds the remapper
//  blk_cnt       out  16       saturating count of blocked bursts, reads plus writes
// BEHAVIOUR
//  Reset: every valid and ready output is 0, both FSMs IDLE, outstanding counters 0, blk_cnt 0.
//  Reset mid-burst abandons the transaction; no completion is generated.
//  Forwarded AW/AR: combinational pass-through, zero latency, address unmodified.
//   Gated (m valid=0, s ready=0) when FSM not IDLE, or that direction's outstanding count == MAX_OUTS.
//  Write FSM:
//   IDLE -> PASS on in-window m AW handshake.
//   IDLE -> DRAIN on out-of-window s AW: accept with awready=1 one cycle, latch awid.
//   PASS: W forwarded combinationally; -> IDLE on wlast handshake. AXI4 W carries no ID, so one burst at a time.
//   DRAIN: s_wready=1, data discarded, m_wvalid=0; -> WAIT on wlast handshake.
//   WAIT: -> RESP when write outstanding count == 0, preserving same-ID B order.
//   RESP: s_bvalid=1, bresp=2'b11, bid=latched; m_bready=0; -> IDLE on s_bready.
//   AW/W/B gated 0 in any state other than those above.
//  Read FSM:
//   IDLE -> ERRWAIT on out-of-window AR: accept, latch arid and arlen.
//   ERRWAIT -> ERR when read outstanding count == 0.
//   ERR: emits arlen+1 beats, rdata=0, rresp=2'b11, rlast on final beat; m_rready=0 throughout.
//   ERR: beat counter 8-bit, advances only on s_rvalid&s_rready; -> IDLE after last beat.
//   In-window reads never change FSM state.
//  Response paths:
//   B and R pass through combinationally whenever the FSM is not in RESP/ERR.
//   Outside those states the error path drives s_bvalid/s_rvalid = 0.
//  Outstanding counters (per direction):
//   +1 on m AW/AR handshake.
//   -1 on forwarded B handshake, or R handshake with rlast.
//   Simultaneous +1/-1 leaves the count unchanged; the counter never wraps.
//  blk_cnt: +1 on each out-of-window AW or AR acceptance; if both occur in one cycle, +2; saturates at 16'hFFFF.
//  Window check applies to the start address only.
//   Legal INCR/WRAP bursts cannot cross a 2^WIN_BITS boundary, since WIN_BITS >= 12.
// STRUCTURE
//  Package axi_guard_pkg: RESP_OKAY=2'b00, RESP_DECERR=2'b11, wr_state_t {IDLE,PASS,DRAIN,WAIT,RESP},
//   rd_state_t {IDLE,ERRWAIT,ERR}.
//  Sub-module axi_guard_outs_ctr (inc, dec, count, full): instantiated once for writes, once for reads.
// TESTING
//  In-window write AW addr 0x0000_1000, len=3, 4 beats -> 4 W beats on m; B OKAY id 5 returned; blk_cnt 0.
//  Write to 0x8000_0000, awid=2, len=1 -> m_awvalid never 1; 2 W beats drained; B resp 2'b11 id 2; blk_cnt 1.
//  Read 0xF000_0000, arid=7, len=3 -> exactly 4 R beats: rdata 0, DECERR, id 7; rlast only on beat 4; m_arvalid never 1.
//  In-window read id 3 outstanding, then blocked read id 3 -> DECERR beats start only after forwarded rlast.
//  15 in-window ARs with m R held off -> 16th AR stalled (s_arready=0) until one rlast completes.
//  Assert aresetn in DRAIN with 1 of 4 beats taken -> all valid/ready 0; after release, fresh in-window write passes.

Source files
------------

// File: rtl/axi_guard_pkg.sv
// Shared types and constants for the AXI address-window guard.
// Response codes, write/read FSM states, saturating counter helper.
package axi_guard_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_PASS,
        WR_DRAIN,
        WR_WAIT,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ERRWAIT,
        RD_ERR
    } rd_state_t;

    function automatic logic [15:0] sat_add16(
        input logic [15:0] a,
        input logic [1:0]  b
    );
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/axi_guard_outs_ctr.sv
// Outstanding-burst counter, one per direction.
// Ports: clk, rst_n, inc, dec -> count, full (count == MAX_OUTS).
module axi_guard_outs_ctr #(
    parameter int MAX_OUTS = 15,
    parameter int CNT_W    = $clog2(MAX_OUTS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTS);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Simultaneous inc/dec cancel; both ends clamp so the count never wraps.
    always_comb begin
        count_d = count_q;
        if (inc && !dec && count_q != MAX_C) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == MAX_C);

endmodule

// File: rtl/axi_addr_guard.sv
// AXI4 address-window firewall: forwards in-window bursts, answers
// out-of-window ones with DECERR. Ports: s_axi_* slave, m_axi_* master, blk_cnt.
module axi_addr_guard
    import axi_guard_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int ID_W     = 4,
    parameter int WIN_BITS = 28,
    parameter logic [ADDR_W-WIN_BITS-1:0] WIN_TAG = '0,
    parameter int MAX_OUTS = 15
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awlock,
    input  logic [3:0]        s_axi_awcache,
    input  logic [2:0]        s_axi_awprot,
    input  logic [3:0]        s_axi_awqos,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arlock,
    input  logic [3:0]        s_axi_arcache,
    input  logic [2:0]        s_axi_arprot,
    input  logic [3:0]        s_axi_arqos,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [ID_W-1:0]   m_axi_awid,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic              m_axi_awlock,
    output logic [3:0]        m_axi_awcache,
    output logic [2:0]        m_axi_awprot,
    output logic [3:0]        m_axi_awqos,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [ID_W-1:0]   m_axi_bid,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ID_W-1:0]   m_axi_arid,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arlock,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [ID_W-1:0]   m_axi_rid,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [15:0]       blk_cnt
);

    localparam int CNT_W = $clog2(MAX_OUTS + 1);

    wr_state_t wr_state_d, wr_state_q;
    rd_state_t rd_state_d, rd_state_q;
    logic [ID_W-1:0] awid_d, awid_q;
    logic [ID_W-1:0] arid_d, arid_q;
    logic [7:0] arlen_d, arlen_q;
    logic [7:0] beat_d, beat_q;
    logic [15:0] blk_cnt_d, blk_cnt_q;

    logic [CNT_W-1:0] wr_cnt, rd_cnt;
    logic wr_full, rd_full;
    logic aw_in_win, ar_in_win;
    logic aw_blk, ar_blk;
    logic aw_fwd_hs, ar_fwd_hs;
    logic wr_inc, wr_dec, rd_inc, rd_dec;
    logic err_last;

    // Address channels pass straight through; only valid/ready are gated.
    assign m_axi_awid    = s_axi_awid;
    assign m_axi_awaddr  = s_axi_awaddr;
    assign m_axi_awlen   = s_axi_awlen;
    assign m_axi_awsize  = s_axi_awsize;
    assign m_axi_awburst = s_axi_awburst;
    assign m_axi_awlock  = s_axi_awlock;
    assign m_axi_awcache = s_axi_awcache;
    assign m_axi_awprot  = s_axi_awprot;
    assign m_axi_awqos   = s_axi_awqos;
    assign m_axi_wdata   = s_axi_wdata;
    assign m_axi_wstrb   = s_axi_wstrb;
    assign m_axi_wlast   = s_axi_wlast;
    assign m_axi_arid    = s_axi_arid;
    assign m_axi_araddr  = s_axi_araddr;
    assign m_axi_arlen   = s_axi_arlen;
    assign m_axi_arsize  = s_axi_arsize;
    assign m_axi_arburst = s_axi_arburst;
    assign m_axi_arlock  = s_axi_arlock;
    assign m_axi_arcache = s_axi_arcache;
    assign m_axi_arprot  = s_axi_arprot;
    assign m_axi_arqos   = s_axi_arqos;

    // Start address alone decides; legal bursts cannot leave the window.
    assign aw_in_win = (s_axi_awaddr[ADDR_W-1:WIN_BITS] == WIN_TAG);
    assign ar_in_win = (s_axi_araddr[ADDR_W-1:WIN_BITS] == WIN_TAG);

    assign aw_blk = (wr_state_q == WR_IDLE) && s_axi_awvalid && !aw_in_win;
    assign ar_blk = (rd_state_q == RD_IDLE) && s_axi_arvalid && !ar_in_win;

    assign m_axi_awvalid = (wr_state_q == WR_IDLE) && !wr_full
                         && s_axi_awvalid && aw_in_win;
    assign m_axi_arvalid = (rd_state_q == RD_IDLE) && !rd_full
                         && s_axi_arvalid && ar_in_win;

    assign aw_fwd_hs = m_axi_awvalid && m_axi_awready;
    assign ar_fwd_hs = m_axi_arvalid && m_axi_arready;

    assign s_axi_awready = aw_fwd_hs || aw_blk;
    assign s_axi_arready = ar_fwd_hs || ar_blk;

    assign err_last = (beat_q == arlen_q);

    assign wr_inc = aw_fwd_hs;
    assign wr_dec = m_axi_bvalid && m_axi_bready;
    assign rd_inc = ar_fwd_hs;
    assign rd_dec = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    axi_guard_outs_ctr #(
        .MAX_OUTS(MAX_OUTS),
        .CNT_W   (CNT_W)
    ) u_wr_ctr (
        .clk  (aclk),
        .rst_n(aresetn),
        .inc  (wr_inc),
        .dec  (wr_dec),
        .count(wr_cnt),
        .full (wr_full)
    );

    axi_guard_outs_ctr #(
        .MAX_OUTS(MAX_OUTS),
        .CNT_W   (CNT_W)
    ) u_rd_ctr (
        .clk  (aclk),
        .rst_n(aresetn),
        .inc  (rd_inc),
        .dec  (rd_dec),
        .count(rd_cnt),
        .full (rd_full)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            awid_q     <= '0;
            arid_q     <= '0;
            arlen_q    <= '0;
            beat_q     <= '0;
            blk_cnt_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awid_q     <= awid_d;
            arid_q     <= arid_d;
            arlen_q    <= arlen_d;
            beat_q     <= beat_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        awid_d     = awid_q;
        unique case (wr_state_q)
            WR_IDLE: begin
                if (aw_fwd_hs) begin
                    wr_state_d = WR_PASS;
                end else if (aw_blk) begin
                    wr_state_d = WR_DRAIN;
                    awid_d     = s_axi_awid;
                end
            end
            WR_PASS: begin
                if (s_axi_wvalid && m_axi_wready && s_axi_wlast) begin
                    wr_state_d = WR_IDLE;
                end
            end
            WR_DRAIN: begin
                if (s_axi_wvalid && s_axi_wlast) begin
                    wr_state_d = WR_WAIT;
                end
            end
            // Hold DECERR until earlier forwarded B's drain (same-ID order).
            WR_WAIT: begin
                if (wr_cnt == '0) begin
                    wr_state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arid_d     = arid_q;
        arlen_d    = arlen_q;
        beat_d     = beat_q;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (ar_blk) begin
                    rd_state_d = RD_ERRWAIT;
                    arid_d     = s_axi_arid;
                    arlen_d    = s_axi_arlen;
                    beat_d     = '0;
                end
            end
            RD_ERRWAIT: begin
                if (rd_cnt == '0) begin
                    rd_state_d = RD_ERR;
                end
            end
            RD_ERR: begin
                if (s_axi_rready) begin
                    if (err_last) begin
                        rd_state_d = RD_IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        blk_cnt_d = sat_add16(blk_cnt_q, {1'b0, aw_blk} + {1'b0, ar_blk});
    end

    always_comb begin
        m_axi_wvalid = 1'b0;
        s_axi_wready = 1'b0;
        s_axi_bvalid = m_axi_bvalid;
        s_axi_bid    = m_axi_bid;
        s_axi_bresp  = m_axi_bresp;
        m_axi_bready = s_axi_bready;
        unique case (wr_state_q)
            WR_PASS: begin
                m_axi_wvalid = s_axi_wvalid;
                s_axi_wready = m_axi_wready;
            end
            WR_DRAIN: begin
                s_axi_wready = 1'b1;
            end
            WR_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bid    = awid_q;
                s_axi_bresp  = RESP_DECERR;
                m_axi_bready = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        s_axi_rvalid = m_axi_rvalid;
        s_axi_rid    = m_axi_rid;
        s_axi_rdata  = m_axi_rdata;
        s_axi_rresp  = m_axi_rresp;
        s_axi_rlast  = m_axi_rlast;
        m_axi_rready = s_axi_rready;
        if (rd_state_q == RD_ERR) begin
            s_axi_rvalid = 1'b1;
            s_axi_rid    = arid_q;
            s_axi_rdata  = '0;
            s_axi_rresp  = RESP_DECERR;
            s_axi_rlast  = err_last;
            m_axi_rready = 1'b0;
        end
    end

    assign blk_cnt = blk_cnt_q;

endmodule

// File: tb/tb_axi_addr_guard.sv
// Directed self-checking bench for axi_addr_guard.
// Drives both AXI sides by hand and checks responses with immediate assertions.
module tb_axi_addr_guard;

    logic clk;
    logic aresetn;

    logic [3:0]  s_awid, s_arid, s_bid, s_rid;
    logic [31:0] s_awaddr, s_araddr;
    logic [7:0]  s_awlen, s_arlen;
    logic [2:0]  s_awsize, s_arsize, s_awprot, s_arprot;
    logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
    logic        s_awlock, s_arlock;
    logic [3:0]  s_awcache, s_arcache, s_awqos, s_arqos;
    logic        s_awvalid, s_awready, s_arvalid, s_arready;
    logic [63:0] s_wdata, s_rdata;
    logic [7:0]  s_wstrb;
    logic        s_wlast, s_wvalid, s_wready;
    logic        s_bvalid, s_bready;
    logic        s_rlast, s_rvalid, s_rready;

    logic [3:0]  m_awid, m_arid, m_bid, m_rid;
    logic [31:0] m_awaddr, m_araddr;
    logic [7:0]  m_awlen, m_arlen;
    logic [2:0]  m_awsize, m_arsize, m_awprot, m_arprot;
    logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
    logic        m_awlock, m_arlock;
    logic [3:0]  m_awcache, m_arcache, m_awqos, m_arqos;
    logic        m_awvalid, m_awready, m_arvalid, m_arready;
    logic [63:0] m_wdata, m_rdata;
    logic [7:0]  m_wstrb;
    logic        m_wlast, m_wvalid, m_wready;
    logic        m_bvalid, m_bready;
    logic        m_rlast, m_rvalid, m_rready;
    logic [15:0] blk_cnt;

    int n_cmp = 0;
    int n_err = 0;

    axi_addr_guard dut (
        .aclk(clk), .aresetn(aresetn),
        .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr),
        .s_axi_awlen(s_awlen), .s_axi_awsize(s_awsize),
        .s_axi_awburst(s_awburst), .s_axi_awlock(s_awlock),
        .s_axi_awcache(s_awcache), .s_axi_awprot(s_awprot),
        .s_axi_awqos(s_awqos), .s_axi_awvalid(s_awvalid),
        .s_axi_awready(s_awready),
        .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb),
        .s_axi_wlast(s_wlast), .s_axi_wvalid(s_wvalid),
        .s_axi_wready(s_wready),
        .s_axi_bid(s_bid), .s_axi_bresp(s_bresp),
        .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
        .s_axi_arid(s_arid), .s_axi_araddr(s_araddr),
        .s_axi_arlen(s_arlen), .s_axi_arsize(s_arsize),
        .s_axi_arburst(s_arburst), .s_axi_arlock(s_arlock),
        .s_axi_arcache(s_arcache), .s_axi_arprot(s_arprot),
        .s_axi_arqos(s_arqos), .s_axi_arvalid(s_arvalid),
        .s_axi_arready(s_arready),
        .s_axi_rid(s_rid), .s_axi_rdata(s_rdata),
        .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast),
        .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
        .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr),
        .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize),
        .m_axi_awburst(m_awburst), .m_axi_awlock(m_awlock),
        .m_axi_awcache(m_awcache), .m_axi_awprot(m_awprot),
        .m_axi_awqos(m_awqos), .m_axi_awvalid(m_awvalid),
        .m_axi_awready(m_awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
        .m_axi_wlast(m_wlast), .m_axi_wvalid(m_wvalid),
        .m_axi_wready(m_wready),
        .m_axi_bid(m_bid), .m_axi_bresp(m_bresp),
        .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
        .m_axi_arid(m_arid), .m_axi_araddr(m_araddr),
        .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize),
        .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock),
        .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot),
        .m_axi_arqos(m_arqos), .m_axi_arvalid(m_arvalid),
        .m_axi_arready(m_arready),
        .m_axi_rid(m_rid), .m_axi_rdata(m_rdata),
        .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
        .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
        .blk_cnt(blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] vr();
        return {s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
    endfunction

    initial begin
        aresetn = 1'b0;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'd3;
        s_awburst = 2'b01; s_awlock = 1'b0; s_awcache = '0;
        s_awprot = '0; s_awqos = '0; s_awvalid = 1'b0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd3;
        s_arburst = 2'b01; s_arlock = 1'b0; s_arcache = '0;
        s_arprot = '0; s_arqos = '0; s_arvalid = 1'b0;
        s_wdata = '0; s_wstrb = 8'hFF; s_wlast = 1'b0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_rready = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
        m_rid = '0; m_rdata = '0; m_rresp = '0;
        m_rlast = 1'b0; m_rvalid = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset_vr", vr(), 10'b0);
        chk("reset_blk", blk_cnt, 16'h0);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);

        // in-window 4-beat write, id 5
        s_awvalid = 1'b1; s_awaddr = 32'h0000_1000;
        s_awid = 4'd5; s_awlen = 8'd3;
        m_awready = 1'b1; m_wready = 1'b1;
        #1;
        chk("wr_fwd_awvalid", m_awvalid, 1'b1);
        chk("wr_fwd_awaddr", m_awaddr, 32'h0000_1000);
        chk("wr_fwd_awready", s_awready, 1'b1);
        @(negedge clk);
        s_awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_wvalid = 1'b1;
            s_wdata = 64'h1111_0000_0000_0000 + 64'(i);
            s_wlast = (i == 3);
            #1;
            chk("wr_fwd_beat", {m_wvalid, m_wlast, m_wdata},
                {1'b1, (i == 3), 64'h1111_0000_0000_0000 + 64'(i)});
            @(negedge clk);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        #1;
        chk("wr_idle_wvalid", m_wvalid, 1'b0);
        m_bvalid = 1'b1; m_bid = 4'd5; m_bresp = 2'b00; s_bready = 1'b1;
        #1;
        chk("wr_fwd_b", {s_bvalid, s_bid, s_bresp, m_bready},
            {1'b1, 4'd5, 2'b00, 1'b1});
        @(negedge clk);
        m_bvalid = 1'b0; s_bready = 1'b0;
        #1;
        chk("wr_fwd_blk", blk_cnt, 16'd0);

        // blocked write to 0x8000_0000, id 2, 2 beats
        s_awvalid = 1'b1; s_awaddr = 32'h8000_0000;
        s_awid = 4'd2; s_awlen = 8'd1;
        #1;
        chk("wr_blk_aw", {m_awvalid, s_awready}, 2'b01);
        @(negedge clk);
        s_awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_wvalid = 1'b1;
            s_wdata = 64'hDEAD_0000 + 64'(i);
            s_wlast = (i == 1);
            #1;
            chk("wr_drain_beat", {s_wready, m_wvalid, m_awvalid}, 3'b100);
            @(negedge clk);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        #1;
        chk("wr_wait_bvalid", s_bvalid, 1'b0);
        @(negedge clk);
        #1;
        chk("wr_err_b", {s_bvalid, s_bid, s_bresp, m_bready},
            {1'b1, 4'd2, 2'b11, 1'b0});
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        #1;
        chk("wr_err_done", s_bvalid, 1'b0);
        chk("wr_err_blk", blk_cnt, 16'd1);

        // blocked read 0xF000_0000, id 7, 4 beats
        s_arvalid = 1'b1; s_araddr = 32'hF000_0000;
        s_arid = 4'd7; s_arlen = 8'd3; m_arready = 1'b1;
        #1;
        chk("rd_blk_ar", {m_arvalid, s_arready}, 2'b01);
        @(negedge clk);
        s_arvalid = 1'b0; s_rready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rd_err_beat", {s_rvalid, s_rid, s_rresp, s_rlast, m_arvalid},
                {1'b1, 4'd7, 2'b11, (i == 3), 1'b0});
            chk("rd_err_data", s_rdata, 64'h0);
            @(negedge clk);
        end
        #1;
        chk("rd_err_done", s_rvalid, 1'b0);
        chk("rd_err_blk", blk_cnt, 16'd2);

        // in-window read id 3 outstanding, then blocked read id 3
        s_arvalid = 1'b1; s_araddr = 32'h0000_2000;
        s_arid = 4'd3; s_arlen = 8'd0;
        #1;
        chk("rd_ord_fwd", m_arvalid, 1'b1);
        @(negedge clk);
        s_araddr = 32'h9000_0000;
        #1;
        chk("rd_ord_blk_ar", {m_arvalid, s_arready}, 2'b01);
        @(negedge clk);
        s_arvalid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rd_ord_stall", s_rvalid, 1'b0);
        m_rvalid = 1'b1; m_rid = 4'd3; m_rlast = 1'b1;
        m_rdata = 64'hABCD; m_rresp = 2'b00;
        #1;
        chk("rd_ord_fwd_r", {s_rvalid, s_rid, s_rresp, s_rlast, m_rready},
            {1'b1, 4'd3, 2'b00, 1'b1, 1'b1});
        chk("rd_ord_fwd_data", s_rdata, 64'hABCD);
        @(negedge clk);
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        chk("rd_ord_gap", s_rvalid, 1'b0);
        @(negedge clk);
        #1;
        chk("rd_ord_err", {s_rvalid, s_rid, s_rresp, s_rlast},
            {1'b1, 4'd3, 2'b11, 1'b1});
        @(negedge clk);
        #1;
        chk("rd_ord_blk", blk_cnt, 16'd3);

        // 15 outstanding reads fill the counter
        m_arready = 1'b1; s_rready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            s_arvalid = 1'b1;
            s_araddr = 32'(i) << 8;
            s_arid = 4'(i);
            @(negedge clk);
        end
        s_araddr = 32'h0000_F000;
        #1;
        chk("full_stall0", {s_arready, m_arvalid}, 2'b00);
        @(negedge clk);
        #1;
        chk("full_stall1", {s_arready, m_arvalid}, 2'b00);
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 4'd0;
        #1;
        chk("full_stall2", s_arready, 1'b0);
        @(negedge clk);
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        chk("full_release", {s_arready, m_arvalid}, 2'b11);
        @(negedge clk);
        s_arvalid = 1'b0;
        m_rvalid = 1'b1; m_rlast = 1'b1;
        repeat (15) @(negedge clk);
        m_rvalid = 1'b0; m_rlast = 1'b0;
        s_rready = 1'b0;

        // reset during drain with 1 of 4 beats taken
        s_awvalid = 1'b1; s_awaddr = 32'hA000_0000;
        s_awid = 4'd1; s_awlen = 8'd3;
        #1;
        chk("rst_blk_aw", s_awready, 1'b1);
        @(negedge clk);
        s_awvalid = 1'b0;
        s_wvalid = 1'b1; s_wlast = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_pre_blk", blk_cnt, 16'd4);
        aresetn = 1'b0;
        #1;
        chk("rst_mid_vr", vr(), 10'b0);
        chk("rst_mid_blk", blk_cnt, 16'd0);
        @(negedge clk);
        aresetn = 1'b1;
        s_wvalid = 1'b0;
        @(negedge clk);
        s_awvalid = 1'b1; s_awaddr = 32'h0000_3000;
        s_awid = 4'd4; s_awlen = 8'd0;
        #1;
        chk("rst_new_aw", {m_awvalid, s_awready}, 2'b11);
        @(negedge clk);
        s_awvalid = 1'b0;
        s_wvalid = 1'b1; s_wlast = 1'b1; s_wdata = 64'h55;
        #1;
        chk("rst_new_w", {m_wvalid, s_wready, m_wdata}, {2'b11, 64'h55});
        @(negedge clk);
        s_wvalid = 1'b0; s_wlast = 1'b0;
        m_bvalid = 1'b1; m_bid = 4'd4; m_bresp = 2'b00; s_bready = 1'b1;
        #1;
        chk("rst_new_b", {s_bvalid, s_bid, s_bresp}, {1'b1, 4'd4, 2'b00});
        @(negedge clk);
        m_bvalid = 1'b0; s_bready = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
